ped_station_ctrl: RTL and testbench

Pedestrian-side station for the traffic-light controller: the opposite end of its pedButton/pedOn/pedLight interface. It conditions the raw crosswalk push-button into a clean one-cycle request pulse for the controller. It mirrors the controller's request-latched status on a WAIT lamp. When the controller grants its PED phase, it sequences the WALK / flashing DON'T WALK signal head with a clearance countdown.

---
 rtl/ped_station_pkg.sv | 17 +
 rtl/ped_station_ctrl_btn_debounce.sv | 45 ++++
 rtl/ped_station_ctrl.sv | 102 ++++++++++
 tb/tb_ped_station_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ped_station_pkg.sv
// ped_station_pkg: shared state encoding and counter-width helper for the pedestrian station.
package ped_station_pkg;

    typedef enum logic [1:0] {
        PS_IDLE  = 2'd0,
        PS_WALK  = 2'd1,
        PS_CLEAR = 2'd2
    } ped_state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ped_station_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-level debounce counter and one-cycle rising-edge flag.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic rise_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);

    logic           sync1_q, sync2_q, level_q, level_d, level_prev_q;
    logic [DW-1:0]  cnt_q, cnt_d;

    // The counter only runs while the synced input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == DW'(DEBOUNCE_CYCLES - 1))
                level_d = ~level_q;
            else
                cnt_d = cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign rise_o = level_q & ~level_prev_q;

endmodule

// File: rtl/ped_station_ctrl.sv
// ped_station_ctrl: pedestrian station - button request pulse, WAIT lamp, WALK / flashing DON'T WALK sequencing.
// Define PED_CHIRP_EN to add the accessible chirp output.
module ped_station_ctrl
    import ped_station_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WALK_CYCLES     = 64,
    parameter int FLASH_CYCLES    = 32,
    parameter int FLASH_HALF      = 4,
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, WALK_CYCLES, FLASH_CYCLES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_raw,
    input  logic             ped_on,
    input  logic             ped_light,
    input  logic             new_cycle,
    output logic             ped_button,
    output logic             wait_lamp,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown
`ifdef PED_CHIRP_EN
    ,
    output logic             chirp
`endif
);
    localparam int              PH_W   = $clog2(2 * FLASH_HALF);
    localparam logic [PH_W-1:0] PH_MAX = PH_W'(2 * FLASH_HALF - 1);

    ped_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             pl1_q, pl2_q, wait_q, ped_button_q, btn_rise, pl_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_i  (btn_raw),
        .rise_o (btn_rise)
    );

    assign pl_rise = pl1_q & ~pl2_q;

    // ph_q is a free-running phase restarted on WALK and CLEAR entry; it drives both flash and chirp.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = (ph_q == PH_MAX) ? '0 : ph_q + PH_W'(1);
        if (state_q == PS_IDLE) begin
            cnt_d = '0;
            ph_d  = '0;
            if (pl_rise) begin
                state_d = PS_WALK;
                cnt_d   = CNT_W'(WALK_CYCLES - 1);
            end
        end else if (state_q == PS_WALK) begin
            if (new_cycle || cnt_q == '0) begin
                state_d = PS_CLEAR;
                cnt_d   = CNT_W'(FLASH_CYCLES - 1);
                ph_d    = '0;
            end else
                cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == PS_CLEAR) begin
            if (cnt_q == '0)
                state_d = PS_IDLE;
            else
                cnt_d = cnt_q - CNT_W'(1);
        end else
            state_d = PS_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PS_IDLE;
            cnt_q        <= '0;
            ph_q         <= '0;
            pl1_q        <= 1'b1;
            pl2_q        <= 1'b1;
            wait_q       <= 1'b0;
            ped_button_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ph_q         <= ph_d;
            pl1_q        <= ped_light;
            pl2_q        <= pl1_q;
            wait_q       <= ped_on;
            ped_button_q <= btn_rise && state_q == PS_IDLE;
        end
    end

    assign ped_button = ped_button_q;
    assign wait_lamp  = wait_q && state_q == PS_IDLE;
    assign walk       = state_q == PS_WALK;
    assign dont_walk  = state_q == PS_IDLE || (state_q == PS_CLEAR && ph_q < PH_W'(FLASH_HALF));
    assign countdown  = (state_q == PS_CLEAR) ? cnt_q : '0;
`ifdef PED_CHIRP_EN
    assign chirp      = state_q == PS_WALK && ph_q == '0;
`endif

endmodule

// File: tb/tb_ped_station_ctrl.sv
// tb_ped_station_ctrl: directed scenarios plus randomized traffic checked against a cycle-count reference model.
module tb_ped_station_ctrl;
    import ped_station_pkg::*;

    localparam int DB = 16, WC = 64, FC = 32, FH = 4;
    localparam int CNT_W = cnt_width(DB, WC, FC);

    logic clk = 1'b0, reset_n = 1'b0, btn_raw = 1'b0, ped_on = 1'b0, ped_light = 1'b1, new_cycle = 1'b0;
    logic ped_button, wait_lamp, walk, dont_walk, chirp;
    logic [CNT_W-1:0] countdown;
    int checks = 0, errs = 0;

    always #5 clk = ~clk;

    ped_station_ctrl #(.DEBOUNCE_CYCLES(DB), .WALK_CYCLES(WC), .FLASH_CYCLES(FC), .FLASH_HALF(FH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw   (btn_raw),
        .ped_on    (ped_on),
        .ped_light (ped_light),
        .new_cycle (new_cycle),
        .ped_button(ped_button),
        .wait_lamp (wait_lamp),
        .walk      (walk),
        .dont_walk (dont_walk),
        .countdown (countdown)
`ifdef PED_CHIRP_EN
        ,
        .chirp     (chirp)
`endif
    );
`ifndef PED_CHIRP_EN
    assign chirp = 1'b0;
`endif

    // Reference model: mode 0/1/2 = idle/walk/clear, m_age = cycles since entering the mode.
    bit raw_q[$], syn_q[$];
    bit m_level = 0, m_flip_up = 0, m_pb = 0, m_pl_prev = 1, m_start = 0, m_wait = 0;
    int m_mode = 0, m_age = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_q.delete();
        syn_q.delete();
        m_level = 0; m_flip_up = 0; m_pb = 0; m_pl_prev = 1; m_start = 0; m_wait = 0;
        m_mode = 0; m_age = 0;
    endtask

    task automatic model_edge();
        bit diff, start_now;
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_pb = m_flip_up && m_mode == 0;
        m_flip_up = 0;
        raw_q.push_back(btn_raw);
        if (raw_q.size() > 3) void'(raw_q.pop_front());
        syn_q.push_back(raw_q.size() == 3 ? raw_q[0] : 1'b0);
        if (syn_q.size() > DB) void'(syn_q.pop_front());
        if (syn_q.size() == DB) begin
            diff = 1;
            foreach (syn_q[i]) if (syn_q[i] == m_level) diff = 0;
            if (diff) begin
                m_level = !m_level;
                m_flip_up = m_level;
            end
        end
        start_now = ped_light && !m_pl_prev;
        m_pl_prev = ped_light;
        if (m_mode == 0) begin
            if (m_start) begin m_mode = 1; m_age = 0; end
        end else if (m_mode == 1) begin
            if (new_cycle || m_age == WC - 1) begin m_mode = 2; m_age = 0; end
            else m_age++;
        end else begin
            if (m_age == FC - 1) begin m_mode = 0; m_age = 0; end
            else m_age++;
        end
        m_start = start_now;
        m_wait = ped_on;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("ped_button", ped_button, m_pb);
        chk("wait_lamp", wait_lamp, m_wait && m_mode == 0);
        chk("walk", walk, m_mode == 1);
        chk("dont_walk", dont_walk, m_mode == 0 || (m_mode == 2 && (m_age / FH) % 2 == 0));
        chk("countdown", countdown, m_mode == 2 ? FC - 1 - m_age : 0);
        chk("walk_excl", walk & dont_walk, 0);
`ifdef PED_CHIRP_EN
        chk("chirp", chirp, m_mode == 1 && m_age % (2 * FH) == 0);
`endif
    endtask

    task automatic wait_walk();
        int n = 0;
        while (!walk && n < 10) begin
            step();
            n++;
        end
        chk("walk_start", walk, 1);
    endtask

    task automatic pulse_light();
        ped_light = 1'b1;
        step();
        ped_light = 1'b0;
    endtask

    initial begin
        int pulses, at, cnt, dark, hb, hl;
        repeat (3) step();
        chk("rst_dont_walk", dont_walk, 1);
        reset_n = 1'b1;
        cnt = 0;
        repeat (6) begin step(); cnt += walk; end
        chk("no_walk_after_rst", cnt, 0);
        ped_light = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 20; i++) begin
            btn_raw = 1'((i / 3) % 2);
            step();
        end
        btn_raw = 1'b1;
        pulses = 0; at = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (ped_button) begin pulses++; at = i; end
        end
        chk("bounce_pulses", pulses, 1);
        chk("bounce_at", at, 19);
        btn_raw = 1'b0;
        pulses = 0;
        repeat (30) begin step(); pulses += ped_button; end
        chk("release_pulses", pulses, 0);

        ped_on = 1'b1;
        step();
        chk("wait_on", wait_lamp, 1);
        pulse_light();
        cnt = 0; dark = 0;
        repeat (110) begin
            step();
            cnt += walk;
            dark += (!walk && !dont_walk);
        end
        chk("walk_len", cnt, WC);
        chk("flash_dark", dark, FC / 2);
        ped_on = 1'b0;

        pulse_light();
        wait_walk();
        cnt = 1;
        while (cnt < 10 && walk) begin step(); cnt++; end
        new_cycle = 1'b1;
        step();
        new_cycle = 1'b0;
        chk("override_walk", walk, 0);
        chk("override_cd", countdown, FC - 1);
        repeat (40) step();

        pulse_light();
        wait_walk();
        btn_raw = 1'b1;
        pulses = 0;
        repeat (30) begin step(); pulses += ped_button; end
        btn_raw = 1'b0;
        repeat (20) begin step(); pulses += ped_button; end
        chk("walk_btn_pulses", pulses, 0);
        cnt = 0;
        while (walk && cnt < 100) begin step(); cnt++; end
        chk("reach_clear", walk, 0);
        repeat (3) step();
        pulse_light();
        cnt = 0;
        repeat (45) begin step(); cnt += walk; end
        chk("clear_rise_ignored", cnt, 0);

        pulse_light();
        wait_walk();
        repeat (5) step();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_dw", dont_walk, 1);
        chk("async_rst_walk", walk, 0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (5) step();

        hb = 0; hl = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hb == 0) begin btn_raw = 1'($urandom_range(0, 1)); hb = $urandom_range(1, 40); end
            if (hl == 0) begin ped_light = 1'($urandom_range(0, 1)); hl = $urandom_range(1, 100); end
            hb--; hl--;
            new_cycle = ($urandom_range(0, 40) == 0);
            ped_on = 1'($urandom_range(0, 1));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
